rs_dec_single_err_locator: RTL and testbench

RS_DEC_SINGLE_ERR_LOCATOR -- requirements
Module: rs_dec_single_err_locator

---
 rtl/rs_dec_single_err_locator_pkg.sv | 19 +
 rtl/gf256_mult.sv | 32 +++
 rtl/rs_dec_single_err_locator.sv | 198 +++++++++++++++++++
 tb/tb_rs_dec_single_err_locator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_dec_single_err_locator_pkg.sv
// Shared constants for the single-error Reed-Solomon locator.
// Holds the GF(256) field polynomial, the primitive element, the code
// length and the locator FSM state encoding.
package rs_dec_single_err_locator_pkg;

    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [8:0] GF_POLY    = 9'h11D;
    // Reduction term applied when a shifted value overflows bit 8.
    localparam logic [7:0] GF_POLY_LO = GF_POLY[7:0];
    localparam logic [7:0] ALPHA      = 8'h02;
    localparam int         CODE_LEN   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_SEARCH = 2'd2
    } state_t;

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(256) multiplier over the field polynomial 0x11D.
// Ports:
//   i_a  operand A
//   i_b  operand B
//   o_p  product A*B in GF(256)
module gf256_mult
    import rs_dec_single_err_locator_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_acc;
    logic [7:0] w_a;

    // Shift-and-add: w_a walks through A*x^i (reduced), accumulated
    // wherever the matching bit of B is set.
    always_comb begin
        w_acc = 8'h00;
        w_a   = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_a;
            end
            w_a = {w_a[6:0], 1'b0} ^ (w_a[7] ? GF_POLY_LO : 8'h00);
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/rs_dec_single_err_locator.sv
// Single-error locator for a 32-byte Reed-Solomon frame.
// Latches four syndromes on i_start, rejects the trivial cases in one
// cycle, then steps a candidate locator p = 1..32 looking for the
// geometric relation S(i+1) = S(i) * alpha^p that a single error implies.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start; results from last evaluation held
// CHECK  | classify latched syndromes, seed X(i) = S(i) * alpha
// SEARCH | compare X(i) against S(i+1), advance X(i) *= alpha, p++
//
// Ports:
//   i_clk, i_resb            clock, synchronous active-low reset
//   i_s0..i_s3               syndromes from the syndrome calculator
//   i_start                  evaluate present syndromes (IDLE only)
//   o_busy                   high while in CHECK or SEARCH
//   o_done                   one-cycle result strobe
//   o_no_err/o_corr/o_uncorr one-hot result class
//   o_err_pos, o_err_mag     located byte index and XOR value
module rs_dec_single_err_locator
    import rs_dec_single_err_locator_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic [7:0] i_s0,
    input  logic [7:0] i_s1,
    input  logic [7:0] i_s2,
    input  logic [7:0] i_s3,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_no_err,
    output logic       o_corr,
    output logic       o_uncorr,
    output logic [4:0] o_err_pos,
    output logic [7:0] o_err_mag
);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_s0, r_s1, r_s2, r_s3;
    logic [7:0] w_s0_nxt, w_s1_nxt, w_s2_nxt, w_s3_nxt;
    logic [7:0] r_x0, r_x1, r_x2;
    logic [7:0] w_x0_nxt, w_x1_nxt, w_x2_nxt;
    logic [5:0] r_p;
    logic [5:0] w_p_nxt;

    logic       r_done, r_no_err, r_corr, r_uncorr;
    logic       w_done_nxt, w_no_err_nxt, w_corr_nxt, w_uncorr_nxt;
    logic [4:0] r_err_pos, w_err_pos_nxt;
    logic [7:0] r_err_mag, w_err_mag_nxt;

    logic [7:0] w_ma0, w_ma1, w_ma2;
    logic [7:0] w_mp0, w_mp1, w_mp2;
    logic       w_match;
    logic [4:0] w_pos;

    // CHECK seeds from the syndromes; SEARCH advances the running X values.
    assign w_ma0 = (r_state == ST_SEARCH) ? r_x0 : r_s0;
    assign w_ma1 = (r_state == ST_SEARCH) ? r_x1 : r_s1;
    assign w_ma2 = (r_state == ST_SEARCH) ? r_x2 : r_s2;

    gf256_mult u_mult0 (.i_a(w_ma0), .i_b(ALPHA), .o_p(w_mp0));
    gf256_mult u_mult1 (.i_a(w_ma1), .i_b(ALPHA), .o_p(w_mp1));
    gf256_mult u_mult2 (.i_a(w_ma2), .i_b(ALPHA), .o_p(w_mp2));

    assign w_match = (r_x0 == r_s1) && (r_x1 == r_s2) && (r_x2 == r_s3);
    // k = 32 - p; modulo 32 that is simply -p on the low five bits.
    assign w_pos   = 5'd0 - r_p[4:0];

    always_comb begin
        w_state_nxt   = r_state;
        w_s0_nxt      = r_s0;
        w_s1_nxt      = r_s1;
        w_s2_nxt      = r_s2;
        w_s3_nxt      = r_s3;
        w_x0_nxt      = r_x0;
        w_x1_nxt      = r_x1;
        w_x2_nxt      = r_x2;
        w_p_nxt       = r_p;
        w_done_nxt    = 1'b0;
        w_no_err_nxt  = r_no_err;
        w_corr_nxt    = r_corr;
        w_uncorr_nxt  = r_uncorr;
        w_err_pos_nxt = r_err_pos;
        w_err_mag_nxt = r_err_mag;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_s0_nxt    = i_s0;
                    w_s1_nxt    = i_s1;
                    w_s2_nxt    = i_s2;
                    w_s3_nxt    = i_s3;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((r_s0 | r_s1 | r_s2 | r_s3) == 8'h00) begin
                    w_done_nxt    = 1'b1;
                    w_no_err_nxt  = 1'b1;
                    w_corr_nxt    = 1'b0;
                    w_uncorr_nxt  = 1'b0;
                    w_err_pos_nxt = 5'd0;
                    w_err_mag_nxt = 8'h00;
                    w_state_nxt   = ST_IDLE;
                end else if (r_s0 == 8'h00) begin
                    w_done_nxt    = 1'b1;
                    w_no_err_nxt  = 1'b0;
                    w_corr_nxt    = 1'b0;
                    w_uncorr_nxt  = 1'b1;
                    w_err_pos_nxt = 5'd0;
                    w_err_mag_nxt = 8'h00;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_x0_nxt    = w_mp0;
                    w_x1_nxt    = w_mp1;
                    w_x2_nxt    = w_mp2;
                    w_p_nxt     = 6'd1;
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_match) begin
                    w_done_nxt    = 1'b1;
                    w_no_err_nxt  = 1'b0;
                    w_corr_nxt    = 1'b1;
                    w_uncorr_nxt  = 1'b0;
                    w_err_pos_nxt = w_pos;
                    w_err_mag_nxt = r_s0;
                    w_state_nxt   = ST_IDLE;
                end else if (r_p == 6'(CODE_LEN)) begin
                    w_done_nxt    = 1'b1;
                    w_no_err_nxt  = 1'b0;
                    w_corr_nxt    = 1'b0;
                    w_uncorr_nxt  = 1'b1;
                    w_err_pos_nxt = 5'd0;
                    w_err_mag_nxt = 8'h00;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_x0_nxt = w_mp0;
                    w_x1_nxt = w_mp1;
                    w_x2_nxt = w_mp2;
                    w_p_nxt  = r_p + 6'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resb) begin
            r_state   <= ST_IDLE;
            r_s0      <= 8'h00;
            r_s1      <= 8'h00;
            r_s2      <= 8'h00;
            r_s3      <= 8'h00;
            r_x0      <= 8'h00;
            r_x1      <= 8'h00;
            r_x2      <= 8'h00;
            r_p       <= 6'd0;
            r_done    <= 1'b0;
            r_no_err  <= 1'b0;
            r_corr    <= 1'b0;
            r_uncorr  <= 1'b0;
            r_err_pos <= 5'd0;
            r_err_mag <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_s0      <= w_s0_nxt;
            r_s1      <= w_s1_nxt;
            r_s2      <= w_s2_nxt;
            r_s3      <= w_s3_nxt;
            r_x0      <= w_x0_nxt;
            r_x1      <= w_x1_nxt;
            r_x2      <= w_x2_nxt;
            r_p       <= w_p_nxt;
            r_done    <= w_done_nxt;
            r_no_err  <= w_no_err_nxt;
            r_corr    <= w_corr_nxt;
            r_uncorr  <= w_uncorr_nxt;
            r_err_pos <= w_err_pos_nxt;
            r_err_mag <= w_err_mag_nxt;
        end
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = r_done;
    assign o_no_err  = r_no_err;
    assign o_corr    = r_corr;
    assign o_uncorr  = r_uncorr;
    assign o_err_pos = r_err_pos;
    assign o_err_mag = r_err_mag;

endmodule

// File: tb/tb_rs_dec_single_err_locator.sv
// Bench for rs_dec_single_err_locator: a result/latency model predicts
// every output each cycle; directed scenarios pin the model with literals.
module tb_rs_dec_single_err_locator;

    logic       i_clk = 1'b0;
    logic       i_resb = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_s0 = 8'h00, i_s1 = 8'h00, i_s2 = 8'h00, i_s3 = 8'h00;
    logic       o_busy, o_done, o_no_err, o_corr, o_uncorr;
    logic [4:0] o_err_pos;
    logic [7:0] o_err_mag;

    rs_dec_single_err_locator dut (
        .i_clk(i_clk), .i_resb(i_resb),
        .i_s0(i_s0), .i_s1(i_s1), .i_s2(i_s2), .i_s3(i_s3),
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_no_err(o_no_err), .o_corr(o_corr), .o_uncorr(o_uncorr),
        .o_err_pos(o_err_pos), .o_err_mag(o_err_mag)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int kind;   // 0 no error, 1 corrected, 2 uncorrectable
        int pos;
        int mag;
        int lat;
    } res_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int x;
        int r;
        x = int'(a);
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] gf_pow(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < n; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    // A single error at k makes the syndromes a geometric series with
    // ratio alpha^(32-k); try every candidate ratio in order.
    function automatic res_t predict(input logic [7:0] s0, s1, s2, s3);
        res_t r;
        logic [7:0] ap;
        r.kind = 2; r.pos = 0; r.mag = 0; r.lat = 1;
        if (s0 == 0 && s1 == 0 && s2 == 0 && s3 == 0) begin
            r.kind = 0;
            return r;
        end
        if (s0 == 0) return r;
        for (int p = 1; p <= 32; p++) begin
            ap = gf_pow(p);
            if (gf_mul(s0, ap) == s1 && gf_mul(s1, ap) == s2 && gf_mul(s2, ap) == s3) begin
                r.kind = 1; r.pos = 32 - p; r.mag = int'(s0); r.lat = 1 + p;
                return r;
            end
        end
        r.lat = 33;
        return r;
    endfunction

    // Cycle model: counts down the predicted latency after an accepted start.
    bit   m_busy = 0, m_done = 0, m_no_err = 0, m_corr = 0, m_uncorr = 0;
    int   m_pos = 0, m_mag = 0, m_rem = 0;
    res_t m_pend;

    always @(posedge i_clk) begin
        if (!i_resb) begin
            m_busy = 0; m_done = 0; m_no_err = 0; m_corr = 0; m_uncorr = 0;
            m_pos = 0; m_mag = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy   = 0;
                    m_done   = 1;
                    m_no_err = (m_pend.kind == 0);
                    m_corr   = (m_pend.kind == 1);
                    m_uncorr = (m_pend.kind == 2);
                    m_pos    = m_pend.pos;
                    m_mag    = m_pend.mag;
                end
            end else if (i_start) begin
                m_pend = predict(i_s0, i_s1, i_s2, i_s3);
                m_rem  = m_pend.lat;
                m_busy = 1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("busy", int'(o_busy), int'(m_busy));
            check("done", int'(o_done), int'(m_done));
            check("no_err", int'(o_no_err), int'(m_no_err));
            check("corr", int'(o_corr), int'(m_corr));
            check("uncorr", int'(o_uncorr), int'(m_uncorr));
            check("err_pos", int'(o_err_pos), m_pos);
            check("err_mag", int'(o_err_mag), m_mag);
        end
    end

    task automatic run_dir(input string nm, input logic [7:0] a, b, c, d,
                           input int e_lat, input int e_kind, input int e_pos, input int e_mag);
        res_t r;
        int n;
        int busy_n;
        bit seen;
        r = predict(a, b, c, d);
        check({nm, " model_lat"}, r.lat, e_lat);
        check({nm, " model_kind"}, r.kind, e_kind);
        @(negedge i_clk);
        i_s0 = a; i_s1 = b; i_s2 = c; i_s3 = d; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        n = 0; busy_n = 0; seen = 0;
        while (n <= 40 && !seen) begin
            if (o_done) seen = 1;
            else begin
                if (o_busy) busy_n++;
                @(negedge i_clk);
                n++;
            end
        end
        check({nm, " done_seen"}, int'(seen), 1);
        check({nm, " latency"}, n, e_lat);
        check({nm, " busy_cycles"}, busy_n, e_lat);
        check({nm, " no_err"}, int'(o_no_err), int'(e_kind == 0));
        check({nm, " corr"}, int'(o_corr), int'(e_kind == 1));
        check({nm, " uncorr"}, int'(o_uncorr), int'(e_kind == 2));
        check({nm, " pos"}, int'(o_err_pos), e_pos);
        check({nm, " mag"}, int'(o_err_mag), e_mag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e, ap, s0, s1, s2, s3;
        int sel, k, guard;

        // model pins
        check("pin gf 5A*2", int'(gf_mul(8'h5A, 8'h02)), 'hB4);
        check("pin gf B4*2", int'(gf_mul(8'hB4, 8'h02)), 'h75);
        check("pin alpha^8", int'(gf_pow(8)), 'h1D);
        check("pin alpha^32", int'(gf_pow(32)), 'h9D);

        i_resb = 1'b0;
        i_start = 1'b1;
        repeat (2) @(negedge i_clk);
        chk_en = 1'b1;
        check("reset busy", int'(o_busy), 0);
        check("reset done", int'(o_done), 0);
        check("reset result", int'({o_no_err, o_corr, o_uncorr}), 0);
        i_start = 1'b0;
        i_resb = 1'b1;
        @(negedge i_clk);

        run_dir("zero", 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
        run_dir("k31", 8'h5A, 8'hB4, 8'h75, 8'hEA, 2, 1, 31, 'h5A);
        run_dir("s0zero", 8'h00, 8'h12, 8'h00, 8'h00, 1, 2, 0, 0);
        run_dir("exhaust", 8'h01, 8'h02, 8'h04, 8'h09, 33, 2, 0, 0);
        run_dir("k0", 8'h01, 8'h9D, gf_pow(64), gf_pow(96), 33, 1, 0, 1);

        // reset mid-search at p=10 with start pulses while busy
        @(negedge i_clk);
        i_s0 = 8'h01; i_s1 = 8'h9D; i_s2 = gf_pow(64); i_s3 = gf_pow(96);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            i_start = (n == 3 || n == 5 || n == 6);
            i_s0 = 8'($urandom_range(0, 255));
            @(negedge i_clk);
        end
        check("pre-reset busy", int'(o_busy), 1);
        check("pre-reset corr held", int'(o_corr), 1);
        i_resb = 1'b0;
        i_start = 1'b1;
        @(negedge i_clk);
        check("post-reset busy", int'(o_busy), 0);
        check("post-reset flags", int'({o_done, o_no_err, o_corr, o_uncorr}), 0);
        check("post-reset pos", int'(o_err_pos), 0);
        check("post-reset mag", int'(o_err_mag), 0);
        i_resb = 1'b1;
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        check("idle after reset", int'(o_busy), 0);

        // randomized evaluations
        for (int t = 0; t < 90; t++) begin
            guard = 0;
            while (m_busy && guard < 50) begin
                @(negedge i_clk);
                guard++;
            end
            check("rand wait bound", int'(guard < 50), 1);
            sel = $urandom_range(0, 9);
            e = 8'($urandom_range(1, 255));
            k = $urandom_range(0, 31);
            ap = gf_pow(32 - k);
            s0 = e; s1 = gf_mul(s0, ap); s2 = gf_mul(s1, ap); s3 = gf_mul(s2, ap);
            if (sel == 4) begin
                s0 = 0; s1 = 0; s2 = 0; s3 = 0;
            end else if (sel == 5) begin
                s0 = 0; s1 = 8'($urandom); s2 = 8'($urandom); s3 = 8'($urandom);
            end else if (sel == 6) begin
                s3 = s3 ^ 8'($urandom_range(1, 255));
            end else if (sel >= 7) begin
                s0 = 8'($urandom); s1 = 8'($urandom); s2 = 8'($urandom); s3 = 8'($urandom);
            end
            i_s0 = s0; i_s1 = s1; i_s2 = s2; i_s3 = s3;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = ($urandom_range(0, 3) == 0);
            guard = 0;
            while (m_busy && guard < 50) begin
                if ($urandom_range(0, 7) == 0) i_start = ~i_start;
                if ($urandom_range(0, 3) == 0) i_s1 = 8'($urandom);
                if (t % 11 == 10 && guard == 5) i_resb = 1'b0;
                else i_resb = 1'b1;
                @(negedge i_clk);
                guard++;
            end
            i_resb = 1'b1;
            i_start = 1'b0;
            if ($urandom_range(0, 1) == 0) @(negedge i_clk);
        end

        repeat (40) @(negedge i_clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
